// File: rtl/multiport_regfile_sb_if.sv
// Bundle of the register-file write, read and issue signals.
// The master modport is the CPU pipeline side; the slave modport is the register file.
interface multiport_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2
);
    logic                  we0;
    logic [AW-1:0]         wa0;
    logic [DATA_W-1:0]     wd0;
    logic                  we1;
    logic [AW-1:0]         wa1;
    logic [DATA_W-1:0]     wd1;
    logic [NRD*AW-1:0]     ra;
    logic [NRD*DATA_W-1:0] rd;
    logic                  iss_valid;
    logic [AW-1:0]         iss_dst;
    logic [NRD-1:0]        rd_pend;
    logic [AW:0]           pend_cnt;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra, iss_valid, iss_dst,
        input  rd, rd_pend, pend_cnt
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra, iss_valid, iss_dst,
        output rd, rd_pend, pend_cnt
    );
endinterface

// File: rtl/multiport_regfile_sb.sv
// Multi-read, dual-write register file with a per-register pending scoreboard.
// Define RF_BYPASS_EN for write-through reads and write-masked pending flags.
module multiport_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    multiport_regfile_sb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_reg;
    logic [DEPTH-1:0]  pend_next;
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  iss_hit;
    logic [AW:0]       pend_cnt_reg;
    logic [AW:0]       pend_cnt_next;

    genvar gi;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [AW-1:0] IDX       = AW'(gi);
            localparam bit            HARD_ZERO = (ZERO_REG != 0) && (gi == 0);

            logic              hit0;
            logic              hit1;
            logic [DATA_W-1:0] data_reg;

            assign hit0 = bus.we0 && (bus.wa0 == IDX) && !HARD_ZERO;
            assign hit1 = bus.we1 && (bus.wa1 == IDX) && !HARD_ZERO;

            assign wr_hit[gi]  = hit0 | hit1;
            assign iss_hit[gi] = bus.iss_valid && (bus.iss_dst == IDX) && !HARD_ZERO;
            // A new producer issued in the same cycle outlives the completing write.
            assign pend_next[gi] = iss_hit[gi] | (pend_reg[gi] & ~wr_hit[gi]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (hit1) begin
                    data_reg <= bus.wd1;
                end else if (hit0) begin
                    data_reg <= bus.wd0;
                end
            end

            assign regs_q[gi] = data_reg;
        end
    endgenerate

    always_comb begin
        pend_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_next = pend_cnt_next + {{AW{1'b0}}, pend_next[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_reg     <= '0;
            pend_cnt_reg <= '0;
        end else begin
            pend_reg     <= pend_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    assign bus.pend_cnt = pend_cnt_reg;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]     addr;
            logic              zero_hit;
            logic [DATA_W-1:0] data;
            logic              pend;

            assign addr     = bus.ra[gi*AW +: AW];
            assign zero_hit = (ZERO_REG != 0) && (addr == '0);

`ifdef RF_BYPASS_EN
            always_comb begin
                if (zero_hit) begin
                    data = '0;
                end else if (bus.we1 && (bus.wa1 == addr)) begin
                    data = bus.wd1;
                end else if (bus.we0 && (bus.wa0 == addr)) begin
                    data = bus.wd0;
                end else begin
                    data = regs_q[addr];
                end
            end

            // The completing write hides the pending flag unless a new producer re-arms it.
            assign pend = pend_reg[addr] & (~wr_hit[addr] | iss_hit[addr]);
`else
            assign data = zero_hit ? '0 : regs_q[addr];
            assign pend = pend_reg[addr];
`endif

            assign bus.rd[gi*DATA_W +: DATA_W] = reset ? '0 : data;
            assign bus.rd_pend[gi]             = !reset && pend;
        end
    endgenerate
endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Bench for multiport_regfile_sb: two DUTs (ZERO_REG 1 and 0) share stimulus and are
// compared every cycle against an array-based model; directed cases pin literal values.
module tb_multiport_regfile_sb;
    localparam int DW  = 32;
    localparam int DEP = 64;
    localparam int N   = 4;
    localparam int AWB = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic             we0 = 0, we1 = 0, iss_valid = 0;
    logic [AWB-1:0]   wa0 = 0, wa1 = 0, iss_dst = 0;
    logic [DW-1:0]    wd0 = 0, wd1 = 0;
    logic [N*AWB-1:0] ra = 0;

    int total  = 0;
    int passed = 0;
    bit run_chk = 1'b1;

    logic [DW-1:0] mreg  [2][DEP];
    bit            mpend [2][DEP];

    multiport_regfile_sb_if #(.DATA_W(DW), .AW(AWB), .NRD(N)) ifa ();
    multiport_regfile_sb_if #(.DATA_W(DW), .AW(AWB), .NRD(N)) ifb ();

    assign ifa.we0 = we0;  assign ifb.we0 = we0;
    assign ifa.wa0 = wa0;  assign ifb.wa0 = wa0;
    assign ifa.wd0 = wd0;  assign ifb.wd0 = wd0;
    assign ifa.we1 = we1;  assign ifb.we1 = we1;
    assign ifa.wa1 = wa1;  assign ifb.wa1 = wa1;
    assign ifa.wd1 = wd1;  assign ifb.wd1 = wd1;
    assign ifa.ra  = ra;   assign ifb.ra  = ra;
    assign ifa.iss_valid = iss_valid;  assign ifb.iss_valid = iss_valid;
    assign ifa.iss_dst   = iss_dst;    assign ifb.iss_dst   = iss_dst;

    multiport_regfile_sb #(.DATA_W(DW), .DEPTH(DEP), .NRD(N), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    multiport_regfile_sb #(.DATA_W(DW), .DEPTH(DEP), .NRD(N), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Model: one list of registers and pending flags per DUT, updated per edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < DEP; a++) begin
                    mreg[d][a]  = '0;
                    mpend[d][a] = 1'b0;
                end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (we0 && !(d == 0 && wa0 == 0)) mreg[d][wa0] = wd0;
                if (we1 && !(d == 0 && wa1 == 0)) mreg[d][wa1] = wd1;
                if (we0) mpend[d][wa0] = 1'b0;
                if (we1) mpend[d][wa1] = 1'b0;
                if (iss_valid && !(d == 0 && iss_dst == 0)) mpend[d][iss_dst] = 1'b1;
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input int d, input logic [AWB-1:0] a);
        if (reset) return '0;
        if (d == 0 && a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
`endif
        return mreg[d][a];
    endfunction

    function automatic logic exp_pend(input int d, input logic [AWB-1:0] a);
        logic written, reissued;
        if (reset) return 1'b0;
        written  = (we0 && wa0 == a) || (we1 && wa1 == a);
        reissued = iss_valid && iss_dst == a;
`ifdef RF_BYPASS_EN
        return mpend[d][a] && !(written && !reissued);
`else
        return mpend[d][a] && (written || !written);
`endif
    endfunction

    function automatic logic [AWB:0] exp_cnt(input int d);
        int c = 0;
        for (int a = 0; a < DEP; a++) c += int'(mpend[d][a]);
        return (AWB+1)'(c);
    endfunction

    task automatic check_dut(input int d, input logic [N*DW-1:0] rdv,
                             input logic [N-1:0] rpv, input logic [AWB:0] pcv);
        logic [N-1:0] ep;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("dut%0d_rd%0d", d, k), {32'h0, rdv[k*DW +: DW]},
                {32'h0, exp_rd(d, ra[k*AWB +: AWB])});
            ep[k] = exp_pend(d, ra[k*AWB +: AWB]);
        end
        chk($sformatf("dut%0d_rd_pend", d), {60'h0, rpv}, {60'h0, ep});
        chk($sformatf("dut%0d_pend_cnt", d), {57'h0, pcv}, {57'h0, exp_cnt(d)});
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            check_dut(0, ifa.rd, ifa.rd_pend, ifa.pend_cnt);
            check_dut(1, ifb.rd, ifb.rd_pend, ifb.pend_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AWB-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return AWB'($urandom_range(0, 7));
        return AWB'($urandom_range(0, DEP-1));
    endfunction

    initial begin
        cyc(); cyc();
        reset = 1'b0;

        // Fill registers 1..31 with their index, then reset mid-cycle.
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; wa0 = AWB'(i); wd0 = DW'(i);
            cyc();
        end
        we0 = 1'b0; ra = '0; ra[AWB-1:0] = 6'd5;
        #1;
        chk("t1_rd5_before_reset", {32'h0, ifa.rd[DW-1:0]}, 64'd5);
        reset = 1'b1;
        #1;
        chk("t1_rd_in_reset", {32'h0, ifa.rd[DW-1:0]}, 64'd0);
        chk("t1_cnt_in_reset", {57'h0, ifa.pend_cnt}, 64'd0);
        we0 = 1'b1; wa0 = 6'd9; wd0 = 32'd99;
        cyc();
        reset = 1'b0; we0 = 1'b0; ra[AWB-1:0] = 6'd9;
        #1;
        chk("t1_no_write_in_reset", {32'h0, ifa.rd[DW-1:0]}, 64'd0);

        // Register 0 hardwired to zero on dut_a, ordinary on dut_b.
        ra = '0; we0 = 1'b1; wa0 = 6'd0; wd0 = 32'hDEAD_BEEF;
        #1;
        chk("t2_zero_rd_before", {32'h0, ifa.rd[DW-1:0]}, 64'd0);
        chk("t2_zero_pend", {60'h0, ifa.rd_pend}, 64'd0);
        cyc();
        we0 = 1'b0;
        #1;
        chk("t2_zero_rd_after", {32'h0, ifa.rd[DW-1:0]}, 64'd0);
        chk("t2_reg0_plain", {32'h0, ifb.rd[DW-1:0]}, 64'hDEAD_BEEF);

        // Both write ports on one address: port 1 wins.
        we0 = 1'b1; we1 = 1'b1; wa0 = 6'd5; wa1 = 6'd5;
        wd0 = 32'h1111_1111; wd1 = 32'h2222_2222; ra[AWB-1:0] = 6'd5;
        #1;
`ifdef RF_BYPASS_EN
        chk("t3_collision_same_cycle", {32'h0, ifa.rd[DW-1:0]}, 64'h2222_2222);
`endif
        cyc();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("t3_collision", {32'h0, ifa.rd[DW-1:0]}, 64'h2222_2222);

        // Write-through visibility on read port 1.
        ra = '0; ra[AWB +: AWB] = 6'd7;
        we0 = 1'b1; wa0 = 6'd7; wd0 = 32'h0000_00A5;
        #1;
`ifdef RF_BYPASS_EN
        chk("t4_bypass_same_cycle", {32'h0, ifa.rd[DW +: DW]}, 64'hA5);
`else
        chk("t4_old_same_cycle", {32'h0, ifa.rd[DW +: DW]}, 64'h0);
`endif
        cyc();
        we0 = 1'b0;
        #1;
        chk("t4_after_edge", {32'h0, ifa.rd[DW +: DW]}, 64'hA5);

        // Scoreboard sequence.
        ra = '0;
        iss_valid = 1'b1; iss_dst = 6'd3; cyc();
        chk("t5_cnt1", {57'h0, ifa.pend_cnt}, 64'd1);
        iss_dst = 6'd4; cyc();
        chk("t5_cnt2", {57'h0, ifa.pend_cnt}, 64'd2);
        iss_dst = 6'd3; cyc();
        chk("t5_cnt2_again", {57'h0, ifa.pend_cnt}, 64'd2);
        we0 = 1'b1; wa0 = 6'd3; wd0 = 32'h33; cyc();
        chk("t5_set_wins_cnt", {57'h0, ifa.pend_cnt}, 64'd2);
        iss_valid = 1'b0; we0 = 1'b0; ra[AWB-1:0] = 6'd3;
        #1;
        chk("t5_reg3_pending", {63'h0, ifa.rd_pend[0]}, 64'd1);
        we0 = 1'b1; wa0 = 6'd4; cyc();
        we0 = 1'b0; ra[AWB-1:0] = 6'd4;
        #1;
        chk("t5_cnt_after_wr4", {57'h0, ifa.pend_cnt}, 64'd1);
        chk("t5_reg4_clear", {63'h0, ifa.rd_pend[0]}, 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 10000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            we0       = $urandom_range(0, 1) == 1;
            we1       = $urandom_range(0, 2) == 0;
            wa0       = rnd_addr();
            wa1       = rnd_addr();
            wd0       = $urandom;
            wd1       = $urandom;
            iss_valid = $urandom_range(0, 2) != 0;
            iss_dst   = rnd_addr();
            for (int k = 0; k < N; k++) ra[k*AWB +: AWB] = rnd_addr();
            cyc();
        end
        reset = 1'b0;
        cyc();
        run_chk = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
